// File: rtl/vga_pkg.sv
// vga_pkg: 800x600@72 timing defaults, sync-axis state encoding and period helper.
package vga_pkg;
   localparam int H_ACTIVE_DEF = 800;
   localparam int H_FP_DEF     = 56;
   localparam int H_SYNC_DEF   = 120;
   localparam int H_BP_DEF     = 64;
   localparam int V_ACTIVE_DEF = 600;
   localparam int V_FP_DEF     = 37;
   localparam int V_SYNC_DEF   = 6;
   localparam int V_BP_DEF     = 23;
   typedef enum logic [1:0] {
      AX_ACTIVE = 2'd0,
      AX_FRONT  = 2'd1,
      AX_SYNC   = 2'd2,
      AX_BACK   = 2'd3
   } axis_state_e;
   function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction
endpackage

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: pixel enable in, registered timing outputs to the colour-pattern logic.
interface vga_sync_gen_if;
   logic       en;
   logic [9:0] hcnt;
   logic [9:0] vcnt;
   logic       nblank;
   logic       hsync;
   logic       vsync;
   logic       line_start;
   logic       frame_start;
   modport master (input en, output hcnt, vcnt, nblank, hsync, vsync, line_start, frame_start);
   modport slave (output en, input hcnt, vcnt, nblank, hsync, vsync, line_start, frame_start);
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: position counter plus ACTIVE/FRONT/SYNC/BACK FSM for one sync axis.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int ACT  = 800,
   parameter int FP   = 56,
   parameter int SYNC = 120,
   parameter int BP   = 64,
   parameter int W    = 11
) (
   input  logic         clk,
   input  logic         nrst,
   input  logic         step,
   output logic [W-1:0] pos,
   output axis_state_e  state,
   output logic         wrap
);
   localparam int TOTAL = axis_total(ACT, FP, SYNC, BP);
   axis_state_e  state_q, state_d;
   logic [W-1:0] pos_q, pos_d, last_pos;
   logic         at_end;
   always_ff @(posedge clk or negedge nrst)
      if (!nrst) begin
         state_q <= AX_ACTIVE;
         pos_q   <= '0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
      end
   // Each state ends at a fixed position, so the FSM just steps through the encoding.
   always_comb begin
      last_pos = state_q == AX_ACTIVE ? W'(ACT - 1) :
                 state_q == AX_FRONT  ? W'(ACT + FP - 1) :
                 state_q == AX_SYNC   ? W'(ACT + FP + SYNC - 1) : W'(TOTAL - 1);
      at_end   = step && pos_q == last_pos;
      state_d  = at_end ? axis_state_e'(state_q + 2'd1) : state_q;
      wrap     = at_end && state_q == AX_BACK;
      pos_d    = !step ? pos_q : wrap ? '0 : pos_q + W'(1);
   end
   assign pos   = pos_q;
   assign state = state_q;
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator; registered coordinates, blanking, syncs and line/frame pulses.
module vga_sync_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF,
   parameter bit SYNC_POL = 1'b1
) (
   input logic            clk,
   input logic            nrst,
   vga_sync_gen_if.master bus
);
   logic [10:0] h_pos;
   logic [9:0]  v_pos;
   axis_state_e h_state, v_state;
   logic        h_wrap, v_wrap_unused;
   logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
   logic        nblank_q, nblank_d, hsync_q, hsync_d, vsync_q, vsync_d;
   logic        line_start_q, line_start_d, frame_start_q, frame_start_d;
   vga_axis_counter #(.ACT(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(11)) u_h (
      .clk(clk), .nrst(nrst), .step(bus.en), .pos(h_pos), .state(h_state), .wrap(h_wrap)
   );
   // The vertical axis steps once per line, on the enabled end-of-line cycle.
   vga_axis_counter #(.ACT(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(10)) u_v (
      .clk(clk), .nrst(nrst), .step(h_wrap), .pos(v_pos), .state(v_state), .wrap(v_wrap_unused)
   );
   always_comb begin
      hcnt_d        = h_state == AX_ACTIVE ? h_pos[9:0] : '0;
      vcnt_d        = v_state == AX_ACTIVE ? v_pos : '0;
      nblank_d      = h_state == AX_ACTIVE && v_state == AX_ACTIVE;
      hsync_d       = h_state == AX_SYNC ? SYNC_POL : ~SYNC_POL;
      vsync_d       = v_state == AX_SYNC ? SYNC_POL : ~SYNC_POL;
      line_start_d  = h_pos == '0;
      frame_start_d = h_pos == '0 && v_pos == '0;
   end
   always_ff @(posedge clk or negedge nrst)
      if (!nrst) begin
         hcnt_q        <= '0;
         vcnt_q        <= '0;
         nblank_q      <= 1'b0;
         hsync_q       <= ~SYNC_POL;
         vsync_q       <= ~SYNC_POL;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else if (bus.en) begin
         hcnt_q        <= hcnt_d;
         vcnt_q        <= vcnt_d;
         nblank_q      <= nblank_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   assign bus.hcnt        = hcnt_q;
   assign bus.vcnt        = vcnt_q;
   assign bus.nblank      = nblank_q;
   assign bus.hsync       = hsync_q;
   assign bus.vsync       = vsync_q;
   assign bus.line_start  = line_start_q;
   assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: default 800x600 build plus a small SYNC_POL=0 build, both checked against a frame-index model.
module tb_vga_sync_gen;
   localparam int FTD = 1040 * 666;
   localparam int SHT = 28;
   localparam int FTS = SHT * 19;
   localparam logic [24:0] RST_D = {20'd0, 1'b0, 1'b0, 1'b0, 2'b00};
   localparam logic [24:0] RST_S = {20'd0, 1'b0, 1'b1, 1'b1, 2'b00};
   logic        clk = 1'b0;
   logic        nrst;
   logic        en;
   int          tests = 0;
   int          fails = 0;
   int          pd, ps;
   logic [24:0] ed, es, od, os;
   vga_sync_gen_if bd ();
   vga_sync_gen_if bs ();
   assign bd.en = en;
   assign bs.en = en;
   vga_sync_gen dut_d (.clk(clk), .nrst(nrst), .bus(bd.master));
   vga_sync_gen #(
      .H_ACTIVE(16), .H_FP(3), .H_SYNC(5), .H_BP(4),
      .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(4), .SYNC_POL(1'b0)
   ) dut_s (.clk(clk), .nrst(nrst), .bus(bs.master));
   assign od = {bd.hcnt, bd.vcnt, bd.nblank, bd.hsync, bd.vsync, bd.line_start, bd.frame_start};
   assign os = {bs.hcnt, bs.vcnt, bs.nblank, bs.hsync, bs.vsync, bs.line_start, bs.frame_start};
   always #5 clk = ~clk;
   // Output for frame index p: {hcnt, vcnt, nblank, hsync, vsync, line_start, frame_start}.
   function automatic logic [24:0] dec(input int p, input int ha, input int hf, input int hs, input int hb,
                                       input int va, input int vf, input int vs, input bit pol);
      int   ht, h, v;
      logic ia, iv, hy, vy;
      ht = ha + hf + hs + hb;
      h  = p % ht;
      v  = p / ht;
      ia = h < ha;
      iv = v < va;
      hy = h >= ha + hf && h < ha + hf + hs;
      vy = v >= va + vf && v < va + vf + vs;
      return {ia ? 10'(h) : 10'd0, iv ? 10'(v) : 10'd0, ia && iv, hy ? pol : ~pol, vy ? pol : ~pol, h == 0, p == 0};
   endfunction
   always @(posedge clk or negedge nrst)
      if (!nrst) begin
         pd <= 0;
         ps <= 0;
         ed <= RST_D;
         es <= RST_S;
      end else if (en) begin
         ed <= dec(pd, 800, 56, 120, 64, 600, 37, 6, 1'b1);
         pd <= (pd + 1) % FTD;
         es <= dec(ps, 16, 3, 5, 4, 10, 2, 3, 1'b0);
         ps <= (ps + 1) % FTS;
      end
   task automatic test_reset;
      nrst = 1'b0;
      en   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (od !== RST_D) begin fails++; $display("FAIL reset_default: got %h want %h", od, RST_D); end
      tests++;
      if (os !== RST_S) begin fails++; $display("FAIL reset_small: got %h want %h", os, RST_S); end
      nrst = 1'b1;
      @(posedge clk);
      #1;
      tests++;
      if ({bd.nblank, bd.hcnt, bd.vcnt, bd.line_start, bd.frame_start} !== {1'b1, 20'd0, 2'b11}) begin
         fails++;
         $display("FAIL first_pixel: got %h want %h", od, {20'd0, 1'b1, 1'b0, 1'b0, 2'b11});
      end
      tests++;
      if ({od, os} !== {ed, es}) begin fails++; $display("FAIL first_model: got %h/%h want %h/%h", od, os, ed, es); end
   endtask
   task automatic test_line;
      int nb = 0, hs_first = -1, hs_last = -1, hs_n = 0, ls_prev = -1, ls_gap = -1, h799 = -1, h800 = -1;
      for (int k = 1; k <= 2080; k++) begin
         @(posedge clk);
         #1;
         tests++;
         if ({od, os} !== {ed, es}) begin fails++; $display("FAIL trace_line k=%0d: got %h/%h want %h/%h", k, od, os, ed, es); end
         if (k >= 1040 && k < 2080) begin
            nb += int'(bd.nblank);
            if (bd.hsync) begin
               if (hs_first < 0) hs_first = k - 1040;
               hs_last = k - 1040;
               hs_n++;
            end
            if (k == 1040 + 799) h799 = int'(bd.hcnt);
            if (k == 1040 + 800) h800 = int'(bd.hcnt);
         end
         if (bd.line_start) begin
            if (ls_prev >= 0) ls_gap = k - ls_prev;
            ls_prev = k;
         end
      end
      tests++;
      if (nb != 800) begin fails++; $display("FAIL line_nblank: got %0d want 800", nb); end
      tests++;
      if (hs_first != 856 || hs_last != 975 || hs_n != 120) begin
         fails++;
         $display("FAIL line_hsync: got %0d..%0d n=%0d want 856..975 n=120", hs_first, hs_last, hs_n);
      end
      tests++;
      if (ls_gap != 1040 || ls_prev != 2080) begin fails++; $display("FAIL line_start_gap: got %0d at %0d want 1040 at 2080", ls_gap, ls_prev); end
      tests++;
      if (h799 != 799 || h800 != 0) begin fails++; $display("FAIL hcnt_edge: got %0d,%0d want 799,0", h799, h800); end
   endtask
   task automatic test_frame;
      int seen = 0, k0 = -1, gap = -1, nb = 0, vs_n = 0, vs_first = -1, hs_n = 0;
      for (int k = 0; k < 3 * FTS && seen < 2; k++) begin
         @(posedge clk);
         #1;
         tests++;
         if ({od, os} !== {ed, es}) begin fails++; $display("FAIL trace_frame k=%0d: got %h/%h want %h/%h", k, od, os, ed, es); end
         if (bs.frame_start) begin
            seen++;
            if (k0 >= 0) gap = k - k0;
            k0 = k;
         end
         if (seen == 1) begin
            nb += int'(bs.nblank);
            hs_n += int'(!bs.hsync);
            if (!bs.vsync) begin
               if (vs_first < 0) vs_first = k - k0;
               vs_n++;
            end
         end
      end
      tests++;
      if (seen != 2 || gap != FTS) begin fails++; $display("FAIL frame_period: got %0d (seen %0d) want %0d", gap, seen, FTS); end
      tests++;
      if (nb != 160) begin fails++; $display("FAIL frame_nblank: got %0d want 160", nb); end
      tests++;
      if (vs_first != 12 * SHT || vs_n != 3 * SHT) begin
         fails++;
         $display("FAIL frame_vsync: got start %0d n=%0d want start %0d n=%0d", vs_first, vs_n, 12 * SHT, 3 * SHT);
      end
      tests++;
      if (hs_n != 19 * 5) begin fails++; $display("FAIL frame_hsync_low: got %0d want %0d", hs_n, 19 * 5); end
   endtask
   task automatic test_en_random;
      logic [49:0] prev;
      logic        was_en;
      prev = {od, os};
      for (int k = 0; k < 3000; k++) begin
         was_en = ($urandom % 10) < 6;
         en     = was_en;
         @(posedge clk);
         #1;
         tests++;
         if ({od, os} !== {ed, es}) begin fails++; $display("FAIL trace_en k=%0d: got %h/%h want %h/%h", k, od, os, ed, es); end
         if (!was_en) begin
            tests++;
            if ({od, os} !== prev) begin fails++; $display("FAIL en_hold k=%0d: got %h want %h", k, {od, os}, prev); end
         end
         prev = {od, os};
      end
      en = 1'b1;
   endtask
   task automatic test_midreset;
      logic found = 1'b0;
      for (int k = 0; k < 2 * FTS && !found; k++) begin
         @(posedge clk);
         #1;
         if (bs.nblank && bs.vcnt == 10'd5 && bs.hcnt == 10'd8) found = 1'b1;
      end
      tests++;
      if (!found) begin fails++; $display("FAIL midreset_reach: got 0 want 1"); end
      nrst = 1'b0;
      #1;
      tests++;
      if ({od, os} !== {RST_D, RST_S}) begin fails++; $display("FAIL midreset_async: got %h/%h want %h/%h", od, os, RST_D, RST_S); end
      @(posedge clk);
      #1;
      nrst = 1'b1;
      @(posedge clk);
      #1;
      tests++;
      if ({bs.nblank, bs.hcnt, bs.vcnt, bs.line_start, bs.frame_start} !== {1'b1, 20'd0, 2'b11}) begin
         fails++;
         $display("FAIL midreset_restart: got %h want %h", os, {20'd0, 1'b1, 1'b1, 1'b1, 2'b11});
      end
      for (int k = 1; k <= FTS + 2; k++) begin
         @(posedge clk);
         #1;
         tests++;
         if ({od, os} !== {ed, es}) begin fails++; $display("FAIL trace_restart k=%0d: got %h/%h want %h/%h", k, od, os, ed, es); end
      end
   endtask
   initial begin
      test_reset();
      test_line();
      test_frame();
      test_en_random();
      test_midreset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
